vend_sequencer: RTL and testbench
=================================

# vend_sequencer

Controller that sits between the coin-slot front ends and the vending `fsm` core. It round-robin arbitrates two coin slots and feeds accepted coins to the `fsm` one at a time. When the `fsm` vends, it pays the change out through a nickel hopper with a req/ack handshake and then clears the `fsm` for the next sale.

## Interface
Parameters:
- `HOP_TIMEOUT`, default 15: consecutive PAYOUT cycles without `hop_ack` before entering FAULT.
- `MAX_CHANGE`, default 4: largest legal `fsm_change` value, in nickels.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `a_valid` in 1: slot A has a coin.
- `a_coin` in 3: slot A coin code.
- `a_ready` out 1: slot A coin taken this cycle.
- `b_valid` in 1: slot B has a coin.
- `b_coin` in 3: slot B coin code.
- `b_ready` out 1: slot B coin taken this cycle.
- `fsm_coin` out 3: coin code to the `fsm` `coin` input; 000 when idle.
- `fsm_clear` out 1: one-cycle clear to the `fsm`. At top level, `fsm` reset = `~reset | fsm_clear`.
- `fsm_vend` in 1: `fsm` vend output.
- `fsm_change` in 3: change owed, in nickels.
- `hop_req` out 1: request one nickel from the hopper.
- `hop_ack` in 1: hopper dispensed one nickel.
- `vend_done` out 1: one-cycle pulse on a detected vend.
- `reject` out 1: one-cycle pulse when an invalid coin was taken.
- `busy` out 1: state != IDLE.
- `fault` out 1: sticky hopper or change fault.

## Operation
- Legal coin codes: NICKEL 001, DIME 010, QUARTER 101. Every other code is invalid.
- States: IDLE, FEED, CHECK, PAYOUT, CLEAR, FAULT.
- **IDLE**
  - Round-robin grant between slots whose `valid` is high. The slot not served last wins. After reset the pointer favours A.
  - `x_ready` = (state==IDLE) & grant_x, combinational. A transfer is `valid & ready`.
  - Valid coin transferred: register it to `fsm_coin` and go to FEED.
  - Invalid coin transferred: pulse `reject` next cycle, stay IDLE, `fsm_coin` stays 000.
  - The pointer flips to the served slot on every transfer, valid or invalid.
- **FEED** (1 cycle): `fsm_coin` = coin. Next state CHECK; `fsm_coin` returns to 000.
- **CHECK** (1 cycle): sample `fsm_vend`.
  - `fsm_vend` = 0: return to IDLE.
  - `fsm_vend` = 1: pulse `vend_done` and latch `fsm_change` into `cnt`.
    - `fsm_change` > `MAX_CHANGE`: go to FAULT.
    - `cnt` == 0: go to CLEAR.
    - Otherwise: go to PAYOUT.
- **PAYOUT**
  - `hop_req` = 1 while `cnt` > 0.
  - Each cycle with `hop_req & hop_ack` decrements `cnt` and zeroes the timeout counter.
  - Each cycle without ack increments the timeout counter. At `HOP_TIMEOUT` go to FAULT.
  - `cnt` reaching 0 goes to CLEAR; `hop_req` drops in the same cycle the last ack is counted.
- **CLEAR** (1 cycle): `fsm_clear` = 1, then IDLE.
- **FAULT**
  - `fault` = 1, `fsm_clear` = 1, `hop_req` = 0, both `ready` = 0.
  - Exit only through `reset`.
- **Reset** (asynchronous, any state, including mid-PAYOUT)
  - State → IDLE, `cnt` and timeout counter → 0, pointer → A.
  - Every output resets to 0: `fsm_coin`=000, `fsm_clear`, `hop_req`, `vend_done`, `reject`, `busy`, `fault`.
  - Change still owed at reset is discarded.

## Timing
- A coin transferred in cycle N:
  - `fsm_coin` valid in N+1.
  - `fsm_vend` sampled in N+2; `vend_done` in N+2.
  - `hop_req` first high in N+3.
- A no-vend coin returns to IDLE in N+3, so the next transfer is possible in N+3.
- An invalid coin: `reject` in N+1; the next transfer is possible in N+1.
- `hop_ack` is only meaningful while `hop_req` = 1. The hopper may ack on consecutive cycles, so peak rate is 1 nickel per cycle.
- Both slots valid continuously: grants alternate A, B, A, …, each separated by the sequence latency.
- `fsm_clear` is exactly one cycle, except that it is held for the whole of FAULT.

## Structure
- Package `vend_pkg`:
  - coin codes (NICKEL, DIME, NICKEL_DIME, DIME_DIME, QUARTER) matching the `fsm`;
  - `fsm` state codes (IDLE..TWENTYFIVE);
  - the sequencer state enum;
  - PRICE_NICKELS = 5.
- Sub-module `rr_arbiter2`: 2-requester round-robin, with inputs `req[1:0]` and `advance` and output `grant[1:0]` (one-hot or zero).
- Everything else lives in `vend_sequencer`: main FSM, 3-bit `cnt`, and a timeout counter of width clog2(`HOP_TIMEOUT`+1).

## Test plan
- Single QUARTER on A with the `fsm` model vending and change 0:
  - `a_ready` in N; `fsm_coin`=101 in N+1; `vend_done` in N+2; `fsm_clear` in N+3; `hop_req` never asserts.
- NICKEL, NICKEL, QUARTER on A (overpay to 35 cents, change 2):
  - after the vend, `hop_req` is high for exactly 2 acked cycles;
  - with `hop_ack` tied high, `hop_req` falls after 2 cycles, then `fsm_clear` pulses once.
- A and B valid continuously with DIMEs:
  - grants alternate A, B, A, B;
  - no two transfers are closer than 3 cycles.
- Invalid code 011 on B:
  - `b_ready` high, `reject` pulse in N+1, `fsm_coin` stays 000, `busy` stays 0.
- `hop_ack` held 0 with change 3:
  - FAULT after 15 cycles;
  - `fault`=1 and `fsm_clear`=1 held, both `ready`=0;
  - after `reset` low, every output is 0.
- `reset` asserted mid-PAYOUT with `cnt`=2:
  - outputs are 0 immediately (asynchronously);
  - after release, a new coin is accepted and no stale `hop_req` appears.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending sequencer: coin codes and state codes of the
// downstream fsm core, the sequencer state enum and the coin legality check.
package vend_pkg;

    localparam logic [2:0] COIN_NICKEL      = 3'b001;
    localparam logic [2:0] COIN_DIME        = 3'b010;
    localparam logic [2:0] COIN_NICKEL_DIME = 3'b011;
    localparam logic [2:0] COIN_DIME_DIME   = 3'b100;
    localparam logic [2:0] COIN_QUARTER     = 3'b101;

    localparam int PRICE_NICKELS = 5;

    // Credit states of the fsm core, listed here so both sides share one encoding.
    typedef enum logic [2:0] {
        FSM_IDLE,
        FSM_FIVE,
        FSM_TEN,
        FSM_FIFTEEN,
        FSM_TWENTY,
        FSM_TWENTYFIVE
    } fsm_state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_CHECK,
        S_PAYOUT,
        S_CLEAR,
        S_FAULT
    } seq_state_t;

    // Only single physical coins may reach the fsm; combined codes are rejected.
    function automatic logic coin_is_legal(input logic [2:0] code);
        return (code == COIN_NICKEL) || (code == COIN_DIME) || (code == COIN_QUARTER);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; after reset requester 0 is favoured and the
// favour moves away from whichever requester was served on each advance.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic prefer_b;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = prefer_b ? 2'b10 : 2'b01;
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prefer_b <= 1'b0;
        end else if (advance) begin
            prefer_b <= grant[0];
        end
    end

endmodule

// File: rtl/vend_sequencer.sv
// Coin-slot sequencer: arbitrates two slots into the fsm core, checks for a vend,
// pays change through a nickel hopper and clears the fsm for the next sale.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int HOP_TIMEOUT = 15,
    parameter int MAX_CHANGE  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       a_valid,
    input  logic [2:0] a_coin,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [2:0] b_coin,
    output logic       b_ready,
    output logic [2:0] fsm_coin,
    output logic       fsm_clear,
    input  logic       fsm_vend,
    input  logic [2:0] fsm_change,
    output logic       hop_req,
    input  logic       hop_ack,
    output logic       vend_done,
    output logic       reject,
    output logic       busy,
    output logic       fault
);

    localparam int TMO_W = $clog2(HOP_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(HOP_TIMEOUT - 1);

    seq_state_t       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [2:0]       coin_q;
    logic             reject_q;
    logic [1:0]       grant;
    logic             take;
    logic [2:0]       coin_in;

    rr_arbiter2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     ({b_valid, a_valid}),
        .advance (take),
        .grant   (grant)
    );

    assign take     = (state_q == S_IDLE) && (grant != 2'b00);
    assign coin_in  = grant[1] ? b_coin : a_coin;
    assign a_ready  = (state_q == S_IDLE) && grant[0];
    assign b_ready  = (state_q == S_IDLE) && grant[1];
    assign fsm_coin = (state_q == S_FEED) ? coin_q : 3'b000;
    assign reject   = reject_q;
    assign busy     = (state_q != S_IDLE);
    assign fault    = (state_q == S_FAULT);

    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = '0;
        fsm_clear = 1'b0;
        hop_req   = 1'b0;
        vend_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (take && coin_is_legal(coin_in)) begin
                    state_d = S_FEED;
                end
            end
            S_FEED: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if (fsm_vend) begin
                    vend_done = 1'b1;
                    cnt_d     = fsm_change;
                    if (int'(fsm_change) > MAX_CHANGE) begin
                        state_d = S_FAULT;
                    end else if (fsm_change == 3'd0) begin
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_PAYOUT;
                    end
                end
            end
            S_PAYOUT: begin
                hop_req = (cnt_q != 3'd0);
                if (hop_req && hop_ack) begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = S_CLEAR;
                    end
                end else begin
                    // A silent hopper for HOP_TIMEOUT requested cycles is a jam.
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_q == TMO_LAST) begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_CLEAR: begin
                fsm_clear = 1'b1;
                state_d   = S_IDLE;
            end
            S_FAULT: begin
                fsm_clear = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            tmo_q    <= '0;
            coin_q   <= 3'b000;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            reject_q <= take && !coin_is_legal(coin_in);
            if (take) begin
                coin_q <= coin_in;
            end
        end
    end

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: a behavioural fsm core and hopper drive the
// DUT while a per-transfer timeline model predicts every output on every cycle.
module tb_vend_sequencer;

    localparam int NCYC       = 8192;
    localparam int INF        = 1 << 30;
    localparam int TIMEOUT    = 15;
    localparam int MAXCHG     = 4;
    localparam int PRICE_CENT = 25;

    logic       clock;
    logic       reset;
    logic       a_valid, b_valid;
    logic [2:0] a_coin, b_coin;
    logic       a_ready, b_ready;
    logic [2:0] fsm_coin;
    logic       fsm_clear;
    logic       fsm_vend;
    logic [2:0] fsm_change;
    logic       hop_req;
    logic       hop_ack;
    logic       vend_done;
    logic       reject;
    logic       busy;
    logic       fault;

    vend_sequencer #(.HOP_TIMEOUT(TIMEOUT), .MAX_CHANGE(MAXCHG)) dut (
        .clock      (clock),
        .reset      (reset),
        .a_valid    (a_valid),
        .a_coin     (a_coin),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_coin     (b_coin),
        .b_ready    (b_ready),
        .fsm_coin   (fsm_coin),
        .fsm_clear  (fsm_clear),
        .fsm_vend   (fsm_vend),
        .fsm_change (fsm_change),
        .hop_req    (hop_req),
        .hop_ack    (hop_ack),
        .vend_done  (vend_done),
        .reject     (reject),
        .busy       (busy),
        .fault      (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic int coin_cents(input logic [2:0] c);
        case (c)
            3'b001:  return 5;
            3'b010:  return 10;
            3'b011:  return 15;
            3'b100:  return 20;
            3'b101:  return 25;
            default: return 0;
        endcase
    endfunction

    function automatic bit legal(input logic [2:0] c);
        return (c == 3'b001) || (c == 3'b010) || (c == 3'b101);
    endfunction

    // Behavioural fsm core: accumulates credit, vends at 25 cents, cleared by fsm_clear.
    int env_credit;
    int extra_change = 0;
    always @(posedge clock or negedge reset) begin
        if (!reset) env_credit <= 0;
        else if (fsm_clear) env_credit <= 0;
        else if (fsm_coin != 3'b000) env_credit <= env_credit + coin_cents(fsm_coin);
    end
    assign fsm_vend   = (env_credit >= PRICE_CENT);
    assign fsm_change = fsm_vend ? 3'(env_credit / 5 - 5 + extra_change) : 3'b000;

    // Timeline model: each transfer writes its future outputs into per-cycle arrays.
    logic [2:0] e_coin  [NCYC];
    bit         e_clear [NCYC];
    bit         e_req   [NCYC];
    bit         e_vend  [NCYC];
    bit         e_rej   [NCYC];
    bit         e_busy  [NCYC];
    bit         ack_set [NCYC];
    bit         ack_val [NCYC];

    int cyc        = 0;
    int free_at    = 0;
    int fault_from = INF;
    int credit_m   = 0;
    int last_vend  = -1;
    int ack_pct    = 100;
    bit prefer_b   = 1'b0;
    bit rand_fill  = 1'b0;

    logic [2:0] a_q[$];
    logic [2:0] b_q[$];

    function automatic bit get_ack(input int p);
        if (!ack_set[p]) begin
            ack_set[p] = 1'b1;
            ack_val[p] = ($urandom_range(0, 99) < ack_pct);
        end
        return ack_val[p];
    endfunction

    function automatic void clear_from(input int first);
        for (int i = first; i < NCYC; i++) begin
            e_coin[i] = 3'b000; e_clear[i] = 0; e_req[i] = 0;
            e_vend[i] = 0; e_rej[i] = 0; e_busy[i] = 0;
        end
    endfunction

    task automatic schedule(input int t, input logic [2:0] coin);
        int change, owed, misses, p;
        if (!legal(coin)) begin
            e_rej[t+1] = 1;
            free_at = t + 1;
            return;
        end
        e_coin[t+1] = coin;
        e_busy[t+1] = 1;
        e_busy[t+2] = 1;
        credit_m += coin_cents(coin);
        if (credit_m < PRICE_CENT) begin
            free_at = t + 3;
            return;
        end
        e_vend[t+2] = 1;
        last_vend = t + 2;
        change = credit_m / 5 - 5 + extra_change;
        credit_m = 0;
        if (change > MAXCHG) begin
            fault_from = t + 3;
            free_at = INF;
            return;
        end
        p = t + 3;
        owed = change;
        misses = 0;
        while (owed > 0) begin
            e_busy[p] = 1;
            e_req[p]  = 1;
            if (get_ack(p)) begin owed--; misses = 0; end
            else misses++;
            p++;
            if (misses == TIMEOUT) begin
                fault_from = p;
                free_at = INF;
                return;
            end
        end
        e_busy[p]  = 1;
        e_clear[p] = 1;
        free_at = p + 1;
    endtask

    function automatic logic [2:0] rand_coin();
        int r;
        logic [2:0] bad [5];
        bad[0] = 3'b000; bad[1] = 3'b011; bad[2] = 3'b100; bad[3] = 3'b110; bad[4] = 3'b111;
        r = $urandom_range(0, 9);
        if (r < 3) return 3'b001;
        if (r < 6) return 3'b010;
        if (r < 8) return 3'b101;
        return bad[$urandom_range(0, 4)];
    endfunction

    task automatic step();
        bit ea, eb, faulted;
        logic [2:0] coin;
        string c;
        @(negedge clock);
        if (rand_fill) begin
            if (a_q.size() < 2 && $urandom_range(0, 99) < 40) a_q.push_back(rand_coin());
            if (b_q.size() < 2 && $urandom_range(0, 99) < 40) b_q.push_back(rand_coin());
        end
        a_valid = (a_q.size() > 0);
        a_coin  = a_valid ? a_q[0] : 3'b000;
        b_valid = (b_q.size() > 0);
        b_coin  = b_valid ? b_q[0] : 3'b000;
        hop_ack = get_ack(cyc);
        #1;
        faulted = (cyc >= fault_from);
        ea = 0;
        eb = 0;
        if (!faulted && cyc >= free_at) begin
            if (a_valid && b_valid) begin ea = !prefer_b; eb = prefer_b; end
            else begin ea = a_valid; eb = b_valid; end
        end
        c = $sformatf("@%0d", cyc);
        check({"a_ready", c},   a_ready,   ea);
        check({"b_ready", c},   b_ready,   eb);
        check({"fsm_coin", c},  fsm_coin,  e_coin[cyc]);
        check({"fsm_clear", c}, fsm_clear, e_clear[cyc] | faulted);
        check({"hop_req", c},   hop_req,   e_req[cyc]);
        check({"vend_done", c}, vend_done, e_vend[cyc]);
        check({"reject", c},    reject,    e_rej[cyc]);
        check({"busy", c},      busy,      e_busy[cyc] | faulted);
        check({"fault", c},     fault,     faulted);
        if (ea || eb) begin
            coin = ea ? a_q.pop_front() : b_q.pop_front();
            prefer_b = ea;
            schedule(cyc, coin);
        end
        cyc++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fsm_coin"},  fsm_coin,  0);
        check({tag, "_fsm_clear"}, fsm_clear, 0);
        check({tag, "_hop_req"},   hop_req,   0);
        check({tag, "_vend_done"}, vend_done, 0);
        check({tag, "_reject"},    reject,    0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_fault"},     fault,     0);
        check({tag, "_a_ready"},   a_ready,   0);
        check({tag, "_b_ready"},   b_ready,   0);
    endtask

    // Reset lands between clock edges so the zero check proves it is asynchronous.
    task automatic do_reset(input string tag);
        @(posedge clock);
        #2;
        a_valid = 0;
        b_valid = 0;
        hop_ack = 0;
        reset   = 0;
        #1;
        check_all_zero(tag);
        repeat (2) @(negedge clock);
        reset = 1;
        a_q.delete();
        b_q.delete();
        clear_from(cyc);
        cyc        = cyc + 4;
        free_at    = cyc;
        fault_from = INF;
        credit_m   = 0;
        prefer_b   = 0;
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            done = (a_q.size() == 0) && (b_q.size() == 0) &&
                   ((cyc >= free_at) || (cyc > fault_from + 3));
        end
        check({tag, "_settled"}, done, 1);
    endtask

    task automatic run_random(input int ncyc, input int pct, input int extra);
        ack_pct = pct;
        extra_change = extra;
        rand_fill = 1;
        for (int i = 0; i < ncyc; i++) begin
            step();
            if (cyc > fault_from + 5) do_reset($sformatf("rnd_reset%0d", cyc));
        end
        rand_fill = 0;
        run_until_idle("rnd_drain", 300);
        if (cyc >= fault_from) do_reset("rnd_end");
        extra_change = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit reached;
        reset = 0;
        a_valid = 0; a_coin = 3'b000;
        b_valid = 0; b_coin = 3'b000;
        hop_ack = 0;
        clear_from(0);
        #3;
        check_all_zero("por");
        @(negedge clock);
        reset = 1;

        // Single quarter on A: exact change, no hopper activity.
        ack_pct = 50;
        a_q.push_back(3'b101);
        run_until_idle("quarter", 20);

        // Overpay to 35 cents with an always-acking hopper: two nickels back.
        ack_pct = 100;
        a_q.push_back(3'b001); a_q.push_back(3'b001); a_q.push_back(3'b101);
        run_until_idle("overpay", 40);

        // Both slots continuously full of dimes: grants must alternate.
        for (int i = 0; i < 4; i++) begin a_q.push_back(3'b010); b_q.push_back(3'b010); end
        run_until_idle("dimes", 80);

        // Invalid combined code on B is taken and rejected.
        b_q.push_back(3'b011);
        run_until_idle("invalid", 10);
        do_reset("rst1");

        // Change 3 with a dead hopper: timeout into FAULT, ready stays low with a coin waiting.
        ack_pct = 0;
        a_q.push_back(3'b010); a_q.push_back(3'b001); a_q.push_back(3'b101);
        run_until_idle("hop_dead", 60);
        a_q.push_back(3'b001);
        repeat (3) step();
        do_reset("rst_fault");

        // Reset during payout with two nickels owed, then a clean sale afterwards.
        ack_pct = 0;
        last_vend = -1;
        a_q.push_back(3'b001); a_q.push_back(3'b001); a_q.push_back(3'b101);
        reached = 0;
        for (int i = 0; i < 40 && !reached; i++) begin
            step();
            reached = (last_vend >= 0) && (cyc > last_vend + 2);
        end
        check("payout_reached", reached, 1);
        do_reset("rst_payout");
        ack_pct = 100;
        b_q.push_back(3'b101);
        run_until_idle("after_reset", 20);

        run_random(1500, 70, 0);
        run_random(1000, 60, 1);
        run_random(600, 20, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
